// File: rtl/fifo_mst_xfer_ctrl.sv
// FT600 FIFO master transfer sequencer: command, optional turnaround, counted data burst.
// Define FIFO_MST_XFER_TMO_EN to build the stall timeout counter and the ERR abort path.
module fifo_mst_xfer_ctrl #(
   parameter int BURST_LEN = 1024,
   parameter int TMO_CYC   = 255
) (
   input  logic        fifoClk,
   input  logic        fifoRst,
   input  logic        grant,
   input  logic [2:0]  t_ep_num,
   input  logic        m_rd_wr,
   input  logic        ft_rxf_n,
   input  logic        ft_txe_n,
   input  logic        wbuf_full,
   input  logic        rbuf_empty,
   output logic        ft_cmd_vld,
   output logic [3:0]  ft_cmd,
   output logic        ft_oe_n,
   output logic        ft_rd_n,
   output logic        ft_wr_n,
   output logic        wbuf_wr,
   output logic        rbuf_rd,
   output logic        idle_st,
   output logic        xfer_done,
   output logic        xfer_err,
   output logic [15:0] beat_cnt
);

   typedef enum logic [2:0] {IDLE, CMD, TURN, DATA, DONE, ERR} state_t;

   if (BURST_LEN < 1 || BURST_LEN > 65535 || TMO_CYC < 1 || TMO_CYC > 65535) begin : g_bad_param
      $error("fifo_mst_xfer_ctrl: BURST_LEN and TMO_CYC must lie in 1..65535");
   end

   state_t state;
   logic   rd_dir;
   logic   in_eval;
   logic   avail;
   logic   drained;
   logic   end_hit;
   logic   tmo_hit;
   logic   beat;
`ifdef FIFO_MST_XFER_TMO_EN
   logic [15:0] stall_cnt;
`endif

   assign rd_dir = ft_cmd[3];

   // Strobes are registered, so the beat decision is taken on the edge that enters the beat cycle:
   // from TURN for reads and from CMD for writes, then every DATA cycle.
   always_comb begin
      in_eval = (state == DATA) || (state == TURN) || ((state == CMD) && !rd_dir);
      avail   = rd_dir ? (!ft_rxf_n && !wbuf_full) : (!ft_txe_n && !rbuf_empty);
      drained = rd_dir ? ft_rxf_n : rbuf_empty;
      end_hit = (state == DATA) &&
                ((beat_cnt == 16'(BURST_LEN)) || ((beat_cnt != 16'd0) && drained));
`ifdef FIFO_MST_XFER_TMO_EN
      tmo_hit = (state == DATA) && !end_hit && (stall_cnt == 16'(TMO_CYC));
`else
      tmo_hit = 1'b0;
`endif
      beat    = in_eval && !end_hit && !tmo_hit && avail;
   end

   always_ff @(posedge fifoClk or posedge fifoRst) begin
      if (fifoRst) begin
         state      <= IDLE;
         ft_cmd_vld <= 1'b0;
         ft_cmd     <= 4'd0;
         ft_oe_n    <= 1'b1;
         ft_rd_n    <= 1'b1;
         ft_wr_n    <= 1'b1;
         wbuf_wr    <= 1'b0;
         rbuf_rd    <= 1'b0;
         idle_st    <= 1'b1;
         xfer_done  <= 1'b0;
         beat_cnt   <= 16'd0;
`ifdef FIFO_MST_XFER_TMO_EN
         xfer_err   <= 1'b0;
         stall_cnt  <= 16'd0;
`endif
      end else begin
         ft_cmd_vld <= 1'b0;
         ft_rd_n    <= 1'b1;
         ft_wr_n    <= 1'b1;
         wbuf_wr    <= 1'b0;
         rbuf_rd    <= 1'b0;
         xfer_done  <= 1'b0;
`ifdef FIFO_MST_XFER_TMO_EN
         xfer_err   <= 1'b0;
`endif
         case (state)
            IDLE: begin
               if (grant) begin
                  state      <= CMD;
                  ft_cmd     <= {m_rd_wr, t_ep_num};
                  ft_cmd_vld <= 1'b1;
                  idle_st    <= 1'b0;
                  beat_cnt   <= 16'd0;
`ifdef FIFO_MST_XFER_TMO_EN
                  stall_cnt  <= 16'd0;
`endif
               end
            end
            CMD: begin
               state   <= rd_dir ? TURN : DATA;
               ft_oe_n <= !rd_dir;
            end
            TURN: state <= DATA;
            DATA: begin
               if (end_hit) begin
                  state     <= DONE;
                  xfer_done <= 1'b1;
                  ft_oe_n   <= 1'b1;
               end
`ifdef FIFO_MST_XFER_TMO_EN
               else if (tmo_hit) begin
                  state    <= ERR;
                  xfer_err <= 1'b1;
                  ft_oe_n  <= 1'b1;
               end
`endif
            end
            DONE, ERR: begin
               state   <= IDLE;
               idle_st <= 1'b1;
            end
            default: state <= IDLE;
         endcase

         if (beat) begin
            beat_cnt <= beat_cnt + 16'd1;
            if (rd_dir) begin
               ft_rd_n <= 1'b0;
               wbuf_wr <= 1'b1;
            end else begin
               ft_wr_n <= 1'b0;
               rbuf_rd <= 1'b1;
            end
         end
`ifdef FIFO_MST_XFER_TMO_EN
         // Any cycle that is evaluated but neither beats nor ends is a stall.
         if (beat)
            stall_cnt <= 16'd0;
         else if (in_eval && !end_hit && !tmo_hit)
            stall_cnt <= stall_cnt + 16'd1;
`endif
      end
   end

`ifndef FIFO_MST_XFER_TMO_EN
   assign xfer_err = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_mst_xfer_ctrl.sv
// Randomized bench for fifo_mst_xfer_ctrl with a procedural per-transaction reference model.
// Honours FIFO_MST_XFER_TMO_EN the same way the design does.
module tb_fifo_mst_xfer_ctrl;

   localparam int BL   = 4;
   localparam int TMO  = 8;
   localparam int MAXC = 300;
   localparam int M_ALL = 0, M_WR3 = 1, M_RDSTALL = 2, M_TXE = 3, M_RAND = 4, M_HEAVY = 5, M_RST = 6;
`ifdef FIFO_MST_XFER_TMO_EN
   localparam bit TMO_EN = 1'b1;
`else
   localparam bit TMO_EN = 1'b0;
`endif

   logic        fifoClk    = 1'b0;
   logic        fifoRst    = 1'b0;
   logic        grant      = 1'b0;
   logic [2:0]  t_ep_num   = 3'd0;
   logic        m_rd_wr    = 1'b0;
   logic        ft_rxf_n   = 1'b1;
   logic        ft_txe_n   = 1'b1;
   logic        wbuf_full  = 1'b0;
   logic        rbuf_empty = 1'b1;
   logic        ft_cmd_vld;
   logic [3:0]  ft_cmd;
   logic        ft_oe_n, ft_rd_n, ft_wr_n, wbuf_wr, rbuf_rd, idle_st, xfer_done, xfer_err;
   logic [15:0] beat_cnt;

   fifo_mst_xfer_ctrl #(.BURST_LEN(BL), .TMO_CYC(TMO)) dut (
      .fifoClk(fifoClk), .fifoRst(fifoRst), .grant(grant), .t_ep_num(t_ep_num),
      .m_rd_wr(m_rd_wr), .ft_rxf_n(ft_rxf_n), .ft_txe_n(ft_txe_n), .wbuf_full(wbuf_full),
      .rbuf_empty(rbuf_empty), .ft_cmd_vld(ft_cmd_vld), .ft_cmd(ft_cmd), .ft_oe_n(ft_oe_n),
      .ft_rd_n(ft_rd_n), .ft_wr_n(ft_wr_n), .wbuf_wr(wbuf_wr), .rbuf_rd(rbuf_rd),
      .idle_st(idle_st), .xfer_done(xfer_done), .xfer_err(xfer_err), .beat_cnt(beat_cnt)
   );

   always #5 fifoClk = ~fifoClk;

   logic        e_cmd_vld, e_oe_n, e_rd_n, e_wr_n, e_wbuf_wr, e_rbuf_rd, e_idle, e_done, e_err;
   logic [3:0]  e_cmd;
   logic [15:0] e_cnt;
   int n_vec = 0, n_err = 0;
   int cyc = 0, done_at = -1, err_at = -1, n_push = 0, n_pop = 0, rst_at = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0h, want %0h", name, $time, act, exp);
      end
   endtask

   task automatic compare();
      chk("ft_cmd_vld", 32'(ft_cmd_vld), 32'(e_cmd_vld));
      chk("ft_cmd",     32'(ft_cmd),     32'(e_cmd));
      chk("ft_oe_n",    32'(ft_oe_n),    32'(e_oe_n));
      chk("ft_rd_n",    32'(ft_rd_n),    32'(e_rd_n));
      chk("ft_wr_n",    32'(ft_wr_n),    32'(e_wr_n));
      chk("wbuf_wr",    32'(wbuf_wr),    32'(e_wbuf_wr));
      chk("rbuf_rd",    32'(rbuf_rd),    32'(e_rbuf_rd));
      chk("idle_st",    32'(idle_st),    32'(e_idle));
      chk("xfer_done",  32'(xfer_done),  32'(e_done));
      chk("xfer_err",   32'(xfer_err),   32'(e_err));
      chk("beat_cnt",   32'(beat_cnt),   32'(e_cnt));
   endtask

   task automatic set_ctl_idle();
      e_cmd_vld = 1'b0; e_oe_n = 1'b1; e_rd_n = 1'b1; e_wr_n = 1'b1;
      e_wbuf_wr = 1'b0; e_rbuf_rd = 1'b0; e_done = 1'b0; e_err = 1'b0; e_idle = 1'b1;
   endtask

   task automatic tick();
      @(posedge fifoClk);
      @(negedge fifoClk);
      cyc++;
      compare();
      if (xfer_done === 1'b1 && done_at < 0) done_at = cyc;
      if (xfer_err === 1'b1 && err_at < 0) err_at = cyc;
      if (wbuf_wr === 1'b1) n_push++;
      if (rbuf_rd === 1'b1) n_pop++;
   endtask

   task automatic rand_in();
      ft_rxf_n   = 1'($urandom_range(0, 1));
      ft_txe_n   = 1'($urandom_range(0, 1));
      wbuf_full  = 1'($urandom_range(0, 1));
      rbuf_empty = 1'($urandom_range(0, 1));
   endtask

   task automatic gen_in(input int mode, input int k, input int cnt);
      rand_in();
      case (mode)
         M_ALL, M_RST: begin ft_rxf_n = 1'b0; ft_txe_n = 1'b0; wbuf_full = 1'b0; rbuf_empty = 1'b0; end
         M_WR3:        begin ft_txe_n = 1'b0; rbuf_empty = (cnt >= 3); end
         M_RDSTALL:    begin ft_rxf_n = 1'b0; wbuf_full = (k >= 2 && k < 7); end
         M_TXE:        begin ft_txe_n = 1'b1; rbuf_empty = 1'b0; end
         M_HEAVY: begin
            ft_rxf_n   = ($urandom_range(0, 3) == 0);
            wbuf_full  = ($urandom_range(0, 3) != 0);
            ft_txe_n   = ($urandom_range(0, 3) != 0);
            rbuf_empty = ($urandom_range(0, 5) == 0);
         end
         default: begin
            ft_rxf_n   = ($urandom_range(0, 7) == 0);
            wbuf_full  = ($urandom_range(0, 3) == 0);
            ft_txe_n   = ($urandom_range(0, 3) == 0);
            rbuf_empty = ($urandom_range(0, 7) == 0);
         end
      endcase
   endtask

   task automatic do_reset();
      #2;
      fifoRst = 1'b1;
      grant   = 1'b0;
      #1;
      e_cmd = 4'd0;
      e_cnt = 16'd0;
      set_ctl_idle();
      compare();
      @(posedge fifoClk);
      @(negedge fifoClk);
      compare();
      fifoRst = 1'b0;
   endtask

   task automatic idle_gap(input int n);
      set_ctl_idle();
      for (int i = 0; i < n; i++) begin
         grant = 1'b0;
         rand_in();
         tick();
      end
   endtask

   // One transaction: res 0 = done, 1 = timeout abort, 2 = left hanging then reset, 3 = reset mid-burst.
   task automatic xfer(input bit rd, input logic [2:0] ep, input int mode, output int res);
      int cnt, stall;
      bit avail, drained;
      cyc = 0; done_at = -1; err_at = -1; n_push = 0; n_pop = 0;
      grant = 1'b1; t_ep_num = ep; m_rd_wr = rd; rand_in();
      set_ctl_idle();
      e_cmd = {rd, ep}; e_cnt = 16'd0; e_cmd_vld = 1'b1; e_idle = 1'b0;
      tick();
      grant = 1'b0;
      e_cmd_vld = 1'b0;
      e_oe_n = !rd;
      if (rd) begin
         rand_in();
         tick();
      end
      cnt = 0; stall = 0; res = 0;
      for (int k = 0; k < MAXC; k++) begin
         if (mode == M_RST && k == rst_at) begin
            do_reset();
            res = 3;
            return;
         end
         if (mode == M_TXE && !TMO_EN && k == 30) begin
            do_reset();
            res = 2;
            return;
         end
         gen_in(mode, k, cnt);
         grant    = (k == 1) || ($urandom_range(0, 7) == 0);
         t_ep_num = 3'($urandom);
         m_rd_wr  = 1'($urandom);
         avail    = rd ? (!ft_rxf_n && !wbuf_full) : (!ft_txe_n && !rbuf_empty);
         drained  = rd ? ft_rxf_n : rbuf_empty;
         e_rd_n = 1'b1; e_wr_n = 1'b1; e_wbuf_wr = 1'b0; e_rbuf_rd = 1'b0;
         if (cnt == BL || (cnt > 0 && drained) || (TMO_EN && stall == TMO)) begin
            e_oe_n = 1'b1;
            if (cnt == BL || (cnt > 0 && drained)) begin
               e_done = 1'b1; res = 0;
            end else begin
               e_err = 1'b1; res = 1;
            end
            tick();
            e_done = 1'b0; e_err = 1'b0; e_idle = 1'b1;
            grant = 1'($urandom);
            rand_in();
            tick();
            grant = 1'b0;
            return;
         end
         if (avail) begin
            cnt++;
            stall = 0;
            if (rd) begin e_rd_n = 1'b0; e_wbuf_wr = 1'b1; end
            else    begin e_wr_n = 1'b0; e_rbuf_rd = 1'b1; end
         end else begin
            stall++;
         end
         e_cnt = 16'(cnt);
         tick();
      end
      n_vec++;
      n_err++;
      $display("FAIL txn_bound: transaction still open after %0d cycles, want an end", MAXC);
      do_reset();
      res = 4;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: time limit reached, want the bench to finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int res;
      set_ctl_idle();
      e_cmd = 4'd0;
      e_cnt = 16'd0;
      #1 fifoRst = 1'b1;
      #2 compare();
      @(negedge fifoClk);
      fifoRst = 1'b0;
      idle_gap(2);

      xfer(1'b1, 3'd3, M_ALL, res);
      chk("rd4_res", 32'(res), 0);
      chk("rd4_done_at", 32'(done_at), 7);
      chk("rd4_pushes", 32'(n_push), 4);
      chk("rd4_beat_cnt", 32'(beat_cnt), 4);
      chk("rd4_cmd_held", 32'(ft_cmd), 32'hB);
      chk("rd4_idle", 32'(idle_st), 1);

      xfer(1'b0, 3'd2, M_WR3, res);
      chk("wr3_beat_cnt", 32'(beat_cnt), 3);
      chk("wr3_pops", 32'(n_pop), 3);
      chk("wr3_done_at", 32'(done_at), 5);

      xfer(1'b1, 3'd1, M_RDSTALL, res);
      chk("rdstall_pushes", 32'(n_push), 4);
      chk("rdstall_err_at", 32'(err_at), 32'hFFFF_FFFF);
      chk("rdstall_done_at", 32'(done_at), 12);
      chk("rdstall_beat_cnt", 32'(beat_cnt), 4);

      xfer(1'b0, 3'd4, M_TXE, res);
      chk("txe_res", 32'(res), TMO_EN ? 1 : 2);
      chk("txe_err_at", 32'(err_at), TMO_EN ? 10 : -1);
      chk("txe_beat_cnt", 32'(beat_cnt), 0);
      chk("txe_cmd", 32'(ft_cmd), TMO_EN ? 4 : 0);

      rst_at = 2;
      xfer(1'b0, 3'd1, M_RST, res);
      chk("rst_res", 32'(res), 3);
      chk("rst_done_at", 32'(done_at), 32'hFFFF_FFFF);
      chk("rst_err_at", 32'(err_at), 32'hFFFF_FFFF);
      idle_gap(1);

      for (int t = 0; t < 200; t++) begin
         int sel, mode;
         sel  = int'($urandom_range(0, 9));
         mode = (sel < 5) ? M_RAND : ((sel < 9) ? M_HEAVY : M_RST);
         if (mode == M_RST) rst_at = int'($urandom_range(0, 4));
         xfer(1'($urandom_range(0, 1)), 3'($urandom_range(1, 4)), mode, res);
         sel = int'($urandom_range(0, 2));
         if (sel > 0) idle_gap(sel);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/fifo_mst_xfer_ctrl.md
# fifo_mst_xfer_ctrl

Transfer sequencer for the FT600 FIFO master datapath. It takes the one-cycle grant, endpoint number and direction from the channel arbiter. It then runs one bus transaction: command phase, optional bus turnaround, and a data burst with beat counting, stall handling and timeout. It returns `idle_st` to the arbiter, so the arbiter only resamples FIFO status between transactions.

## Interface
Parameters:
- `BURST_LEN`, 1024: maximum 32-bit beats per transaction; legal range 1..65535.
- `TMO_CYC`, 255: number of consecutive stall cycles that aborts a transaction; legal range 1..65535.

Ports:
- `fifoClk` in 1: single clock.
- `fifoRst` in 1: reset, asynchronous assert, active-high.
- `grant` in 1: one-cycle start pulse from the arbiter.
- `t_ep_num` in 3: granted endpoint, 1..4.
- `m_rd_wr` in 1: direction; 1 = read from FT600 OUT endpoint, 0 = write to IN endpoint.
- `ft_rxf_n` in 1: FT600 read data available, active-low.
- `ft_txe_n` in 1: FT600 write space available, active-low.
- `wbuf_full` in 1: memory-side receive buffer full.
- `rbuf_empty` in 1: memory-side transmit buffer empty.
- `ft_cmd_vld` out 1: command phase strobe.
- `ft_cmd` out 4: `{m_rd_wr, ep[2:0]}`, latched at grant.
- `ft_oe_n` out 1: FT600 output enable, active-low.
- `ft_rd_n` out 1: read beat strobe, active-low.
- `ft_wr_n` out 1: write beat strobe, active-low.
- `wbuf_wr` out 1: push one beat into the receive buffer.
- `rbuf_rd` out 1: pop one beat from the transmit buffer.
- `idle_st` out 1: controller is idle; feeds the arbiter.
- `xfer_done` out 1: one-cycle pulse on normal completion.
- `xfer_err` out 1: one-cycle pulse on timeout abort.
- `beat_cnt` out 16: beats moved by the last transaction; held until the next grant.

## Operation
- States: IDLE, CMD, TURN, DATA, DONE, ERR.
- **IDLE**
  - `idle_st`=1.
  - On `grant`, latch `t_ep_num` and `m_rd_wr`, clear the beat counter, clear the stall counter, and go to CMD.
  - `grant` in any other state is ignored.
- **CMD**
  - `ft_cmd_vld`=1 for exactly one cycle.
  - Next state: TURN if read, DATA if write.
- **TURN** (read only)
  - `ft_oe_n`=0, no beat.
  - Next state: DATA.
- **DATA, read**
  - `ft_oe_n` stays 0.
  - Beat when `~ft_rxf_n & ~wbuf_full`: `ft_rd_n`=0, `wbuf_wr`=1, count+1.
  - Stall cycle: `wbuf_full`=1, or `ft_rxf_n`=1 while count=0.
  - End: count reaches `BURST_LEN` on the beat cycle, or `ft_rxf_n`=1 with count≥1 (short packet). Go to DONE.
- **DATA, write**
  - Beat when `~ft_txe_n & ~rbuf_empty`: `ft_wr_n`=0, `rbuf_rd`=1, count+1.
  - Stall cycle: `ft_txe_n`=1, or `rbuf_empty`=1 while count=0.
  - End: count reaches `BURST_LEN`, or `rbuf_empty`=1 with count≥1. Go to DONE.
- **Stall counter**
  - Increments on each stall cycle; clears on any beat.
  - When it equals `TMO_CYC`, go to ERR.
  - End conditions take priority over timeout in the same cycle.
- **DONE**: `xfer_done`=1, `ft_oe_n`=1, `beat_cnt` updated; next state IDLE.
- **ERR**: `xfer_err`=1, `ft_oe_n`=1, `beat_cnt` = beats completed; next state IDLE.
- `ft_cmd` holds its latched value until the next grant.
- Beat counter is 16 bits. It saturates at `BURST_LEN` by construction and never wraps.

## Timing
- Reset values: `idle_st`=1; `ft_oe_n`, `ft_rd_n`, `ft_wr_n`=1; all other outputs 0; state IDLE. Assertion takes effect immediately and aborts any transaction without pulsing `xfer_done` or `xfer_err`.
- `grant` sampled at edge N:
  - `idle_st` goes to 0 and `ft_cmd_vld` to 1 in cycle N+1.
  - First possible read beat in cycle N+3; first possible write beat in N+2.
- All strobes are registered outputs, asserted in the same cycle as the qualifying inputs were true on the previous edge. Beat throughput is 1 per cycle.
- After the last beat: DONE for one cycle, then IDLE. Back-to-back `grant` is accepted in the first IDLE cycle.
- Fixed overhead per transaction: read 4 cycles, write 3 cycles (excluding beats).

## Configuration
- `FIFO_MST_XFER_TMO_EN` defined: stall counter and ERR state are present; behaviour as above.
- Not defined: stall counter and ERR logic are removed and `xfer_err` is tied 0. A stalled transaction waits indefinitely in DATA until an end condition or reset.

## Test plan
- Read, `BURST_LEN`=4, `ft_rxf_n`=0 throughout, `wbuf_full`=0 → CMD at N+1, TURN at N+2, 4 `wbuf_wr` pulses N+3..N+6, `xfer_done` at N+7, `beat_cnt`=4, `idle_st`=1 at N+8.
- Write, `rbuf_empty` rises after 3 beats → `xfer_done`, `beat_cnt`=3, `ft_wr_n` never low while `rbuf_empty`=1.
- Read with `wbuf_full`=1 for 5 cycles mid-burst, `TMO_CYC`=255 → `ft_rd_n` held high during the stall, burst resumes, total count correct, no `xfer_err`.
- Write with `ft_txe_n`=1 permanently, `TMO_CYC`=8, macro defined → `xfer_err` after 8 stall cycles, `beat_cnt`=0, then IDLE. Same test with macro undefined → stays in DATA.
- `grant` pulsed during DATA → ignored, `ft_cmd` unchanged. `fifoRst` asserted mid-burst → all `_n` outputs high immediately and `idle_st`=1, no done or err pulse.
